iram_port_sched: RTL and testbench

- Sequences and shares the single internal-RAM data port between two requesters: core direct/indirect byte accesses, and the stack engine.
- The stack engine performs 1- or 2-byte PUSH/POP for PUSH/POP, LCALL/ACALL/RET/RETI and interrupt entry.
- Owns the 8051 stack pointer (SFR 0x81) and performs pre-increment push / post-decrement pop.
- Sits between the control unit and the internal RAM module.

---
 rtl/iram_port_sched.sv | 154 +++++++++++++++
 tb/tb_iram_port_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_port_sched.sv
// iram_port_sched: shares the internal-RAM data port between core byte accesses and the stack engine.
// Optional feature: define IRAM_STACK_BOUNDS_EN to reject stack operations that leave [SP_RESET, SP_LIMIT].
module iram_port_sched #(
   parameter logic [7:0] SP_RESET = 8'h07,
   parameter logic [7:0] SP_LIMIT = 8'h7F
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [7:0]  core_addr,
   input  logic [7:0]  core_wdata,
   output logic        core_ack,
   output logic [7:0]  core_rdata,
   input  logic        stk_req,
   input  logic        stk_pop,
   input  logic        stk_two,
   input  logic [15:0] stk_wdata,
   output logic        stk_ack,
   output logic [15:0] stk_rdata,
   output logic        stk_err,
   input  logic        sp_wr_en,
   input  logic [7:0]  sp_wr_data,
   output logic        sp_wr_drop,
   output logic [7:0]  sp,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wr_byte,
   input  logic [7:0]  mem_rd_byte
);

`ifdef IRAM_STACK_BOUNDS_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      IDLE, CORE_ISSUE, CORE_DONE, PUSH_LO, PUSH_HI, POP_HI, POP_LO, POP_CAP, STK_DONE
   } state_t;

   state_t      state, state_nx;
   logic        last_grant;
   logic        op_we, op_two, op_err;
   logic [7:0]  core_rdata_q;
   logic [15:0] stk_rdata_q;
   logic [7:0]  sp_eff, sp_inc;
   logic [8:0]  nbytes;
   logic        gnt_stk, gnt_core, reject;

   // An SP write in the grant cycle lands first, so the bounds check sees the new value
   assign sp_eff   = sp_wr_en ? sp_wr_data : sp;
   assign sp_inc   = sp + 8'd1;
   assign nbytes   = stk_two ? 9'd2 : 9'd1;
   assign gnt_stk  = (state == IDLE) && stk_req && (!core_req || !last_grant);
   assign gnt_core = (state == IDLE) && core_req && !gnt_stk;
   assign reject   = BOUNDS_EN && (stk_pop ? ({1'b0, sp_eff} < {1'b0, SP_RESET} + nbytes)
                                           : ({1'b0, sp_eff} + nbytes > {1'b0, SP_LIMIT}));

   assign core_ack   = state == CORE_DONE;
   assign stk_ack    = state == STK_DONE;
   assign stk_err    = stk_ack && op_err;
   assign core_rdata = (core_ack && !op_we) ? mem_rd_byte : core_rdata_q;
   assign stk_rdata  = stk_rdata_q;
   assign sp_wr_drop = sp_wr_en && (state != IDLE);

   // State register
   always_ff @(posedge clock)
      state <= !reset ? IDLE : state_nx;

   // Next-state: arbitration in IDLE, then a fixed walk through each operation
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       state_nx = gnt_core ? CORE_ISSUE : !gnt_stk ? IDLE : reject ? STK_DONE :
                                !stk_pop ? PUSH_LO : stk_two ? POP_HI : POP_LO;
         CORE_ISSUE: state_nx = CORE_DONE;
         PUSH_LO:    state_nx = op_two ? PUSH_HI : STK_DONE;
         PUSH_HI:    state_nx = STK_DONE;
         POP_HI:     state_nx = POP_LO;
         POP_LO:     state_nx = POP_CAP;
         POP_CAP:    state_nx = STK_DONE;
         default:    state_nx = IDLE;
      endcase
   end

   // RAM port drive: pushes address the pre-incremented SP, pops the current SP
   always_comb begin
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = 8'h00;
      mem_wr_byte = 8'h00;
      case (state)
         CORE_ISSUE: begin
            mem_rd_en   = !op_we;
            mem_wr_en   = op_we;
            mem_addr    = core_addr;
            mem_wr_byte = core_wdata;
         end
         PUSH_LO: begin
            mem_wr_en   = 1'b1;
            mem_addr    = sp_inc;
            mem_wr_byte = stk_wdata[7:0];
         end
         PUSH_HI: begin
            mem_wr_en   = 1'b1;
            mem_addr    = sp_inc;
            mem_wr_byte = stk_wdata[15:8];
         end
         POP_HI, POP_LO: begin
            mem_rd_en   = 1'b1;
            mem_addr    = sp;
         end
         default: ;
      endcase
   end

   // Datapath: stack pointer, grant history, latched operation attributes and captured read data
   always_ff @(posedge clock) begin
      if (!reset) begin
         sp           <= SP_RESET;
         last_grant   <= 1'b0;
         op_we        <= 1'b0;
         op_two       <= 1'b0;
         op_err       <= 1'b0;
         core_rdata_q <= 8'h00;
         stk_rdata_q  <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (sp_wr_en) sp <= sp_wr_data;
               if (gnt_core || gnt_stk) last_grant <= gnt_stk;
               if (gnt_core) op_we <= core_we;
               if (gnt_stk) begin
                  op_two      <= stk_two;
                  op_err      <= reject;
                  stk_rdata_q <= 16'h0000;
               end
            end
            CORE_DONE: if (!op_we) core_rdata_q <= mem_rd_byte;
            PUSH_LO, PUSH_HI: sp <= sp_inc;
            POP_HI: sp <= sp - 8'd1;
            POP_LO: begin
               sp <= sp - 8'd1;
               if (op_two) stk_rdata_q[15:8] <= mem_rd_byte;
            end
            POP_CAP: stk_rdata_q[7:0] <= mem_rd_byte;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iram_port_sched.sv
// tb_iram_port_sched: directed table, hand-written corner sequences and randomized ops against a stack/RAM model.
module tb_iram_port_sched;

   localparam int CR = 0, CW = 1, PU = 2, PO = 3;
   localparam int SP_RESET = 7, SP_LIMIT = 127;
`ifdef IRAM_STACK_BOUNDS_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   typedef struct {
      int          kind;
      bit          two;
      logic [7:0]  addr;
      logic [15:0] data;
      bit          spw;
      logic [7:0]  spv;
      logic [15:0] rd;
      logic [7:0]  sp;
      bit          err;
      int          lat;
      int          wr;
      int          rdc;
   } vec_t;

   logic        clock = 1'b0, reset;
   logic        core_req, core_we, core_ack;
   logic [7:0]  core_addr, core_wdata, core_rdata;
   logic        stk_req, stk_pop, stk_two, stk_ack, stk_err;
   logic [15:0] stk_wdata, stk_rdata;
   logic        sp_wr_en, sp_wr_drop;
   logic [7:0]  sp_wr_data, sp;
   logic        mem_rd_en, mem_wr_en;
   logic [7:0]  mem_addr, mem_wr_byte;
   logic [7:0]  mem_rd_byte = 8'h00;

   logic [7:0]  ram  [256] = '{default: 8'h00};
   logic [7:0]  mram [256] = '{default: 8'h00};
   logic [7:0]  m_sp = 8'h07;
   int          wr_cnt = 0, rd_cnt = 0;
   int          checks = 0, errors = 0;
   vec_t        tbl[$];

   iram_port_sched dut (
      .clock(clock), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_ack(core_ack), .core_rdata(core_rdata),
      .stk_req(stk_req), .stk_pop(stk_pop), .stk_two(stk_two), .stk_wdata(stk_wdata),
      .stk_ack(stk_ack), .stk_rdata(stk_rdata), .stk_err(stk_err),
      .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data), .sp_wr_drop(sp_wr_drop), .sp(sp),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_byte(mem_wr_byte), .mem_rd_byte(mem_rd_byte)
   );

   always #5 clock = ~clock;

   // Internal RAM with registered read, plus strobe counters
   always @(posedge clock) begin
      if (mem_wr_en) ram[mem_addr] <= mem_wr_byte;
      if (mem_rd_en) mem_rd_byte <= ram[mem_addr];
      if (mem_wr_en) wr_cnt <= wr_cnt + 1;
      if (mem_rd_en) rd_cnt <= rd_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t v(int kind, bit two, logic [7:0] addr, logic [15:0] data, bit spw,
                              logic [7:0] spv, logic [15:0] rd, logic [7:0] spx, bit err,
                              int lat, int wr, int rdc);
      vec_t r;
      r.kind = kind; r.two = two; r.addr = addr; r.data = data; r.spw = spw; r.spv = spv;
      r.rd = rd; r.sp = spx; r.err = err; r.lat = lat; r.wr = wr; r.rdc = rdc;
      return r;
   endfunction

   // Reference: SP moves by whole bytes, pushes pre-increment, pops post-decrement
   task automatic model_op(input vec_t t, output vec_t e);
      int n;
      e = t;
      n = t.two ? 2 : 1;
      e.rd = 16'h0000; e.err = 1'b0; e.wr = 0; e.rdc = 0;
      if (t.spw) m_sp = t.spv;
      if (t.kind == CR) begin
         e.rd = {8'h00, mram[t.addr]}; e.lat = 2; e.rdc = 1;
      end else if (t.kind == CW) begin
         mram[t.addr] = t.data[7:0]; e.lat = 2; e.wr = 1;
      end else if (t.kind == PU) begin
         if (BOUNDS && int'(m_sp) + n > SP_LIMIT) begin
            e.err = 1'b1; e.lat = 1;
         end else begin
            for (int i = 0; i < n; i++) begin
               m_sp = m_sp + 8'd1;
               mram[m_sp] = t.data[8*i +: 8];
            end
            e.lat = n + 1; e.wr = n;
         end
      end else begin
         if (BOUNDS && int'(m_sp) - SP_RESET < n) begin
            e.err = 1'b1; e.lat = 1;
         end else begin
            for (int i = 0; i < n; i++) begin
               e.rd = {e.rd[7:0], mram[m_sp]};
               m_sp = m_sp - 8'd1;
            end
            e.lat = n + 2; e.rdc = n;
         end
      end
      e.sp = m_sp;
   endtask

   task automatic do_op(input vec_t t, output logic [15:0] rd, output bit err, output int lat,
                        output int wrs, output int rds, output logic [7:0] spa);
      int w0, r0;
      bit done;
      @(negedge clock);
      core_req = t.kind < 2; core_we = t.kind == CW; core_addr = t.addr; core_wdata = t.data[7:0];
      stk_req = t.kind >= 2; stk_pop = t.kind == PO; stk_two = t.two; stk_wdata = t.data;
      sp_wr_en = t.spw; sp_wr_data = t.spv;
      w0 = wr_cnt; r0 = rd_cnt; lat = 0; done = 1'b0; rd = 16'h0; err = 1'b0; spa = 8'h00;
      while (!done && lat < 20) begin
         @(posedge clock); #1;
         sp_wr_en = 1'b0;
         lat++;
         if ((t.kind < 2) ? core_ack : stk_ack) begin
            rd = (t.kind < 2) ? {8'h00, core_rdata} : stk_rdata;
            err = stk_err; spa = sp; done = 1'b1;
         end
      end
      core_req = 1'b0; stk_req = 1'b0;
      chk("ack_timeout", 32'(done), 1);
      wrs = wr_cnt - w0; rds = rd_cnt - r0;
      @(posedge clock); #1;
   endtask

   task automatic run_vec(input vec_t t, input vec_t e, input string tag);
      logic [15:0] rd;
      logic [7:0]  spa;
      bit          err;
      int          lat, wrs, rds;
      do_op(t, rd, err, lat, wrs, rds, spa);
      chk($sformatf("%s latency", tag), lat, e.lat);
      chk($sformatf("%s sp", tag), spa, e.sp);
      chk($sformatf("%s stk_err", tag), 32'(err), 32'(e.err));
      chk($sformatf("%s writes", tag), wrs, e.wr);
      chk($sformatf("%s reads", tag), rds, e.rdc);
      if (t.kind == CR || t.kind == PO) chk($sformatf("%s rdata", tag), rd, e.rd);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b0; core_req = 1'b0; stk_req = 1'b0; sp_wr_en = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      reset = 1'b1;
      m_sp = 8'h07;
   endtask

   initial begin
      vec_t e, t;
      int   cyc, nack, bad, sel;
      logic [31:0] seq, cyc_log;
      logic [7:0]  picks [8];
      reset = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
      stk_req = 1'b0; stk_pop = 1'b0; stk_two = 1'b0; stk_wdata = 16'h0;
      sp_wr_en = 1'b0; sp_wr_data = 8'h00;
      picks = '{8'h07, 8'h08, 8'h09, 8'h7E, 8'h7F, 8'h00, 8'hFF, 8'h80};
      repeat (2) @(posedge clock);
      #1;
      chk("reset sp", sp, 8'h07);
      chk("reset strobes", {core_ack, stk_ack, stk_err, sp_wr_drop, mem_rd_en, mem_wr_en}, 0);
      chk("reset rdata", {core_rdata, stk_rdata}, 0);
      @(negedge clock);
      reset = 1'b1;

      tbl.push_back(v(CW, 0, 8'h30, 16'h005A, 0, 8'h00, 16'h0000, 8'h07, 0, 2, 1, 0));
      tbl.push_back(v(CR, 0, 8'h30, 16'h0000, 0, 8'h00, 16'h005A, 8'h07, 0, 2, 0, 1));
      tbl.push_back(v(PU, 1, 8'h00, 16'h1234, 0, 8'h00, 16'h0000, 8'h09, 0, 3, 2, 0));
      tbl.push_back(v(CR, 0, 8'h08, 16'h0000, 0, 8'h00, 16'h0034, 8'h09, 0, 2, 0, 1));
      tbl.push_back(v(CR, 0, 8'h09, 16'h0000, 0, 8'h00, 16'h0012, 8'h09, 0, 2, 0, 1));
      tbl.push_back(v(PO, 1, 8'h00, 16'h0000, 0, 8'h00, 16'h1234, 8'h07, 0, 4, 0, 2));
      tbl.push_back(v(PU, 0, 8'h00, 16'h00AB, 0, 8'h00, 16'h0000, 8'h08, 0, 2, 1, 0));
      tbl.push_back(v(PO, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h00AB, 8'h07, 0, 3, 0, 1));
      tbl.push_back(v(CW, 0, 8'h07, 16'h00C3, 0, 8'h00, 16'h0000, 8'h07, 0, 2, 1, 0));
`ifdef IRAM_STACK_BOUNDS_EN
      tbl.push_back(v(PU, 1, 8'h00, 16'hBEEF, 1, 8'h7E, 16'h0000, 8'h7E, 1, 1, 0, 0));
      tbl.push_back(v(CR, 0, 8'h7F, 16'h0000, 0, 8'h00, 16'h0000, 8'h7E, 0, 2, 0, 1));
      tbl.push_back(v(CR, 0, 8'h80, 16'h0000, 0, 8'h00, 16'h0000, 8'h7E, 0, 2, 0, 1));
`else
      tbl.push_back(v(PU, 1, 8'h00, 16'hBEEF, 1, 8'h7E, 16'h0000, 8'h80, 0, 3, 2, 0));
      tbl.push_back(v(CR, 0, 8'h7F, 16'h0000, 0, 8'h00, 16'h00EF, 8'h80, 0, 2, 0, 1));
      tbl.push_back(v(CR, 0, 8'h80, 16'h0000, 0, 8'h00, 16'h00BE, 8'h80, 0, 2, 0, 1));
`endif
      tbl.push_back(v(PU, 0, 8'h00, 16'h0055, 1, 8'h7E, 16'h0000, 8'h7F, 0, 2, 1, 0));
`ifdef IRAM_STACK_BOUNDS_EN
      tbl.push_back(v(PU, 0, 8'h00, 16'h0066, 0, 8'h00, 16'h0000, 8'h7F, 1, 1, 0, 0));
      tbl.push_back(v(PO, 0, 8'h00, 16'h0000, 1, 8'h07, 16'h0000, 8'h07, 1, 1, 0, 0));
      tbl.push_back(v(PO, 1, 8'h00, 16'h0000, 1, 8'h08, 16'h0000, 8'h08, 1, 1, 0, 0));
`else
      tbl.push_back(v(PU, 0, 8'h00, 16'h0066, 0, 8'h00, 16'h0000, 8'h80, 0, 2, 1, 0));
      tbl.push_back(v(PO, 0, 8'h00, 16'h0000, 1, 8'h07, 16'h00C3, 8'h06, 0, 3, 0, 1));
      tbl.push_back(v(PO, 1, 8'h00, 16'h0000, 1, 8'h08, 16'hABC3, 8'h06, 0, 4, 0, 2));
`endif
      tbl.push_back(v(PO, 1, 8'h00, 16'h0000, 1, 8'h09, 16'h12AB, 8'h07, 0, 4, 0, 2));
`ifdef IRAM_STACK_BOUNDS_EN
      tbl.push_back(v(PU, 0, 8'h00, 16'h0077, 1, 8'hFF, 16'h0000, 8'hFF, 1, 1, 0, 0));
      tbl.push_back(v(PO, 0, 8'h00, 16'h0000, 1, 8'h00, 16'h0000, 8'h00, 1, 1, 0, 0));
`else
      tbl.push_back(v(PU, 0, 8'h00, 16'h0077, 1, 8'hFF, 16'h0000, 8'h00, 0, 2, 1, 0));
      tbl.push_back(v(PO, 0, 8'h00, 16'h0000, 1, 8'h00, 16'h0077, 8'hFF, 0, 3, 0, 1));
`endif
      for (int i = 0; i < tbl.size(); i++) begin
         model_op(tbl[i], e);
         run_vec(tbl[i], tbl[i], $sformatf("vec%0d", i));
      end

      // Tie: both held from reset, stack must win first and grants alternate
      apply_reset();
      @(negedge clock);
      core_we = 1'b0; core_addr = 8'h30; stk_pop = 1'b0; stk_two = 1'b0; stk_wdata = 16'h0011;
      core_req = 1'b1; stk_req = 1'b1;
      cyc = 0; nack = 0; seq = 0; cyc_log = 0;
      while (nack < 4 && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
         if (core_ack || stk_ack) begin
            seq = {seq[27:0], core_ack ? 4'hC : 4'h5};
            cyc_log = {cyc_log[23:0], 8'(cyc)};
            if (core_ack) chk("tie core_rdata", core_rdata, 8'h5A);
            nack++;
            if (nack == 4) begin core_req = 1'b0; stk_req = 1'b0; end
         end
      end
      core_req = 1'b0; stk_req = 1'b0;
      chk("tie order", seq, 32'h00005C5C);
      chk("tie ack cycles", cyc_log, 32'h0205080B);
      chk("tie sp", sp, 8'h09);
      m_sp = 8'h09; mram[8'h08] = 8'h11; mram[8'h09] = 8'h11;
      @(posedge clock); #1;

      // SP write during PUSH_HI is dropped and the push finishes normally
      @(negedge clock);
      stk_req = 1'b1; stk_pop = 1'b0; stk_two = 1'b1; stk_wdata = 16'hA55A;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("push_hi port", {mem_wr_en, mem_addr, mem_wr_byte}, {1'b1, 8'h0B, 8'hA5});
      sp_wr_en = 1'b1; sp_wr_data = 8'h40;
      #1;
      chk("drop pulse", sp_wr_drop, 1'b1);
      @(posedge clock); #1;
      sp_wr_en = 1'b0; stk_req = 1'b0;
      chk("drop ack", stk_ack, 1'b1);
      chk("drop sp", sp, 8'h0B);
      #1;
      chk("drop clears", sp_wr_drop, 1'b0);
      m_sp = 8'h0B; mram[8'h0A] = 8'h5A; mram[8'h0B] = 8'hA5;
      @(posedge clock); #1;

      // Reset during POP_LO aborts without an ack
      @(negedge clock);
      stk_req = 1'b1; stk_pop = 1'b1; stk_two = 1'b1;
      @(posedge clock); #1;
      chk("pop_hi port", {mem_rd_en, mem_addr}, {1'b1, 8'h0B});
      @(posedge clock); #1;
      chk("pop_lo port", {mem_rd_en, mem_addr, sp}, {1'b1, 8'h0A, 8'h0A});
      reset = 1'b0; stk_req = 1'b0;
      @(posedge clock); #1;
      chk("abort sp", sp, 8'h07);
      chk("abort strobes", {core_ack, stk_ack, stk_err, mem_rd_en, mem_wr_en}, 0);
      chk("abort rdata", {core_rdata, stk_rdata}, 0);
      @(negedge clock);
      reset = 1'b1;
      nack = 0;
      repeat (4) begin
         @(posedge clock); #1;
         if (stk_ack || core_ack) nack++;
      end
      chk("abort no ack", nack, 0);
      m_sp = 8'h07;

      // Randomized single-requester traffic against the model
      for (int i = 0; i < 250; i++) begin
         t.kind = $urandom_range(0, 3);
         t.two = 1'($urandom_range(0, 1));
         t.addr = 8'($urandom);
         t.data = 16'($urandom);
         t.spw = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 8);
         t.spv = (sel == 8) ? 8'($urandom) : picks[sel];
         model_op(t, e);
         run_vec(t, e, $sformatf("rnd%0d", i));
      end

      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== mram[i]) bad++;
      chk("ram image", bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
